// File: rtl/servo_sweep_master.sv
// AXI4-Lite write-only master that enables the servo slave, sweeps its angle
// register between min and max with a dwell per step, and disables it on stop.
module servo_sweep_master #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          DWELL_W   = 24
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         min_angle,
  input  logic [7:0]         max_angle,
  input  logic [7:0]         step,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic [31:0]        AWADDR,
  output logic               AWVALID,
  input  logic               AWREADY,
  output logic [2:0]         AWPROT,
  output logic [31:0]        WDATA,
  output logic [3:0]         WSTRB,
  output logic               WVALID,
  input  logic               WREADY,
  input  logic               BVALID,
  output logic               BREADY,
  input  logic [1:0]         BRESP,
  output logic               busy,
  output logic               error,
  output logic [7:0]         cur_angle
);

  // state   | meaning
  // IDLE    | waiting for a start pulse
  // EN_REQ  | writing 0x1111_1111 to the enable register
  // EN_RSP  | waiting for the enable write response
  // ANG_REQ | writing the current angle
  // ANG_RSP | waiting for the angle write response
  // DWELL   | holding the angle for max(dwell,1) cycles
  // DIS_REQ | writing 0 to the enable register
  // DIS_RSP | waiting for the disable write response
  typedef enum logic [2:0] {
    IDLE, EN_REQ, EN_RSP, ANG_REQ, ANG_RSP, DWELL, DIS_REQ, DIS_RSP
  } state_t;

  state_t state_q, state_d;

  logic [7:0]         min_q, max_q, step_q, angle_q, angle_nxt;
  logic               dir_up_q, dir_nxt;
  logic [DWELL_W-1:0] dwell_q, cnt_q;
  logic               aw_done_q, w_done_q, stop_pend_q;
  logic               req_st, req_first, aw_hs, w_hs, req_done;
  logic               stop_eff, cfg_ok, resp_ok;
  logic               set_err, upd_cur, load_cnt, adv_ang;
  logic [8:0]         sum9, lim9;
  logic [31:0]        req_addr, req_data;

  assign AWPROT = 3'b000;
  assign WSTRB  = 4'hF;
  assign BREADY = (state_q == EN_RSP) || (state_q == ANG_RSP) || (state_q == DIS_RSP);
  assign busy   = (state_q != IDLE);

  assign cfg_ok    = (max_angle <= 8'd180) && (min_angle <= max_angle) && (step != 8'd0);
  assign resp_ok   = (BRESP == 2'b00);
  assign stop_eff  = stop_pend_q || stop;
  assign req_st    = (state_q == EN_REQ) || (state_q == ANG_REQ) || (state_q == DIS_REQ);
  assign req_first = !AWVALID && !WVALID && !aw_done_q && !w_done_q;
  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign req_done  = (aw_done_q || aw_hs) && (w_done_q || w_hs);

  // 9-bit sums so angle+step never wraps past 255 before the clamp
  always_comb begin
    sum9      = {1'b0, angle_q} + {1'b0, step_q};
    lim9      = {1'b0, min_q} + {1'b0, step_q};
    angle_nxt = angle_q;
    dir_nxt   = dir_up_q;
    if (dir_up_q) begin
      if (sum9 >= {1'b0, max_q}) begin
        angle_nxt = max_q;
        dir_nxt   = 1'b0;
      end else begin
        angle_nxt = sum9[7:0];
      end
    end else if ({1'b0, angle_q} <= lim9) begin
      angle_nxt = min_q;
      dir_nxt   = 1'b1;
    end else begin
      angle_nxt = angle_q - step_q;
    end
  end

  always_comb begin
    req_addr = BASE_ADDR + 32'd4;
    req_data = 32'h0;
    case (state_q)
      EN_REQ:  req_data = 32'h1111_1111;
      ANG_REQ: begin
        req_addr = BASE_ADDR;
        req_data = {24'b0, angle_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    set_err  = 1'b0;
    upd_cur  = 1'b0;
    load_cnt = 1'b0;
    adv_ang  = 1'b0;
    case (state_q)
      IDLE:    if (start && cfg_ok) state_d = EN_REQ;
      EN_REQ:  if (req_done) state_d = EN_RSP;
      ANG_REQ: if (req_done) state_d = ANG_RSP;
      DIS_REQ: if (req_done) state_d = DIS_RSP;
      EN_RSP: begin
        if (BVALID) begin
          if (!resp_ok) begin
            set_err = 1'b1;
            state_d = DIS_REQ;
          end else begin
            state_d = stop_eff ? DIS_REQ : ANG_REQ;
          end
        end
      end
      ANG_RSP: begin
        if (BVALID) begin
          if (!resp_ok) begin
            set_err = 1'b1;
            state_d = DIS_REQ;
          end else begin
            upd_cur  = 1'b1;
            load_cnt = 1'b1;
            state_d  = stop_eff ? DIS_REQ : DWELL;
          end
        end
      end
      DWELL: begin
        if (stop_eff) begin
          state_d = DIS_REQ;
        end else if (cnt_q <= DWELL_W'(1)) begin
          adv_ang = 1'b1;
          state_d = ANG_REQ;
        end
      end
      DIS_RSP: begin
        if (BVALID) begin
          set_err = !resp_ok;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      error       <= 1'b0;
      cur_angle   <= 8'd0;
      min_q       <= 8'd0;
      max_q       <= 8'd0;
      step_q      <= 8'd0;
      dwell_q     <= '0;
      angle_q     <= 8'd0;
      dir_up_q    <= 1'b0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        error    <= !cfg_ok;
        min_q    <= min_angle;
        max_q    <= max_angle;
        step_q   <= step;
        dwell_q  <= dwell_cycles;
        angle_q  <= min_angle;
        dir_up_q <= 1'b1;
      end else if (set_err) begin
        error <= 1'b1;
      end
      if (state_q == IDLE)
        stop_pend_q <= 1'b0;
      else if (stop)
        stop_pend_q <= 1'b1;
      if (upd_cur)
        cur_angle <= angle_q;
      if (load_cnt)
        cnt_q <= (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
      else if (state_q == DWELL)
        cnt_q <= cnt_q - DWELL_W'(1);
      if (adv_ang) begin
        angle_q  <= angle_nxt;
        dir_up_q <= dir_nxt;
      end
    end
  end

  // VALIDs rise on the first request cycle and each drops after its own handshake
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      AWADDR    <= 32'h0;
      WDATA     <= 32'h0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (req_st) begin
      if (req_first) begin
        AWVALID <= 1'b1;
        WVALID  <= 1'b1;
        AWADDR  <= req_addr;
        WDATA   <= req_data;
      end else begin
        if (aw_hs) begin
          AWVALID   <= 1'b0;
          aw_done_q <= 1'b1;
        end
        if (w_hs) begin
          WVALID   <= 1'b0;
          w_done_q <= 1'b1;
        end
        if (req_done) begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_sweep_master.sv
// Scoreboard bench for servo_sweep_master: a slave model answers writes, a
// monitor pops expected writes on each B handshake and checks protocol rules.
module tb_servo_sweep_master;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        ACLK, ARESETn, start, stop;
  logic [7:0]  min_angle, max_angle, step;
  logic [23:0] dwell_cycles;
  logic [31:0] AWADDR, WDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [2:0]  AWPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP;
  logic        busy, error;
  logic [7:0]  cur_angle;

  servo_sweep_master #(.BASE_ADDR(BASE), .DWELL_W(24)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .stop(stop),
    .min_angle(min_angle), .max_angle(max_angle), .step(step),
    .dwell_cycles(dwell_cycles), .AWADDR(AWADDR), .AWVALID(AWVALID),
    .AWREADY(AWREADY), .AWPROT(AWPROT), .WDATA(WDATA), .WSTRB(WSTRB),
    .WVALID(WVALID), .WREADY(WREADY), .BVALID(BVALID), .BREADY(BREADY),
    .BRESP(BRESP), .busy(busy), .error(error), .cur_angle(cur_angle)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int total = 0, bad = 0;
  logic [63:0] exp_q[$];
  int test_id = 0, aw_delay = 0, w_delay = 0, err_idx = -1, exp_int = 0;
  int nb = 0, cyc = 0, awv_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // slave model: ready after a programmable wait (0 = always ready)
  initial begin : slave
    logic aw_h, w_h, b_h, aw_got, w_got;
    int aw_cnt, w_cnt, wr_idx, slv_test;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; wr_idx = 0; slv_test = 0;
    forever begin
      @(negedge ACLK);
      aw_h = AWVALID && AWREADY;
      w_h  = WVALID && WREADY;
      b_h  = BVALID && BREADY;
      @(posedge ACLK);
      #1;
      if (test_id != slv_test) begin
        slv_test = test_id;
        wr_idx = 0;
      end
      if (!ARESETn) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      if (aw_h) aw_got = 1;
      if (w_h) w_got = 1;
      if (b_h) begin
        BVALID = 0;
        BRESP = 0;
      end
      if (aw_got && w_got && !BVALID) begin
        BVALID = 1;
        BRESP = (wr_idx == err_idx) ? 2'b10 : 2'b00;
        wr_idx++;
        aw_got = 0;
        w_got = 0;
      end
      if (aw_delay == 0) AWREADY = 1;
      else if (AWREADY) begin AWREADY = 0; aw_cnt = 0; end
      else if (AWVALID) begin
        if (aw_cnt >= aw_delay) AWREADY = 1; else aw_cnt++;
      end
      if (w_delay == 0) WREADY = 1;
      else if (WREADY) begin WREADY = 0; w_cnt = 0; end
      else if (WVALID) begin
        if (w_cnt >= w_delay) WREADY = 1; else w_cnt++;
      end
    end
  end

  // monitor: handshakes are judged on the negedge before the edge that takes them
  initial begin : monitor
    logic p_awv, p_wv, chk_cur, chk_idle;
    logic [31:0] p_awaddr, p_wdata, cap_a, cap_d;
    logic [63:0] e;
    logic [7:0] exp_cur;
    int aw_n, w_n, prev_ang, mon_test;
    p_awv = 0; p_wv = 0; chk_cur = 0; chk_idle = 0; exp_cur = 0;
    aw_n = 0; w_n = 0; prev_ang = -1; mon_test = 0; cap_a = 0; cap_d = 0;
    p_awaddr = 0; p_wdata = 0;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (!ARESETn) begin
        p_awv = 0; p_wv = 0; chk_cur = 0; chk_idle = 0; exp_cur = 0;
        aw_n = 0; w_n = 0;
        continue;
      end
      if (test_id != mon_test) begin
        mon_test = test_id;
        prev_ang = -1;
      end
      if (chk_cur) chk("cur_angle", cur_angle, exp_cur);
      if (chk_idle) chk("busy_after_disable", busy, 0);
      chk_cur = 0;
      chk_idle = 0;
      if (p_awv && AWVALID) chk("awaddr_stable", AWADDR, p_awaddr);
      if (p_wv && WVALID) chk("wdata_stable", WDATA, p_wdata);
      if (BREADY) chk("bready_during_request", AWVALID || WVALID, 0);
      if (AWVALID) awv_cnt++;
      if (AWVALID && AWREADY) begin aw_n++; cap_a = AWADDR; end
      if (WVALID && WREADY) begin w_n++; cap_d = WDATA; end
      if (BVALID && BREADY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr %0h data %0h with empty queue", cap_a, cap_d);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", cap_a, e[63:32]);
          chk("write_data", cap_d, e[31:0]);
        end
        chk("aw_handshakes", aw_n, 1);
        chk("w_handshakes", w_n, 1);
        aw_n = 0;
        w_n = 0;
        if (cap_a == BASE) begin
          if (BRESP == 2'b00) exp_cur = cap_d[7:0];
          chk_cur = 1;
          if (exp_int != 0 && prev_ang >= 0) chk("angle_interval", cyc - prev_ang, exp_int);
          prev_ang = cyc;
        end
        if (cap_a == BASE + 32'd4 && cap_d == 32'h0) chk_idle = 1;
        nb++;
      end
      p_awv = AWVALID; p_wv = WVALID; p_awaddr = AWADDR; p_wdata = WDATA;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic start_sweep(input logic [7:0] mn, input logic [7:0] mx,
                             input logic [7:0] st, input logic [23:0] dw);
    @(posedge ACLK); #1;
    min_angle = mn; max_angle = mx; step = st; dwell_cycles = dw; start = 1;
    @(posedge ACLK); #1;
    start = 0;
  endtask

  task automatic pulse_stop;
    @(posedge ACLK); #1;
    stop = 1;
    @(posedge ACLK); #1;
    stop = 0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_nb(input int n);
    int t = 0;
    while (nb < n && t < 3000) begin @(negedge ACLK); #1; t++; end
    chk("wait_b_timeout", nb >= n, 1);
  endtask

  task automatic wait_idle;
    int t = 0;
    while (busy && t < 3000) begin @(negedge ACLK); #1; t++; end
    chk("wait_idle_timeout", busy, 0);
  endtask

  initial begin : stim
    int base, lat, t;
    int a_basic[6] = '{10, 20, 30, 20, 10, 20};
    int a_clamp[8] = '{0, 10, 20, 25, 15, 5, 0, 10};
    int bp_aw[2] = '{4, 1};
    int bp_w[2]  = '{1, 4};
    logic [7:0] inv[3][3] = '{'{8'd0, 8'd200, 8'd10}, '{8'd50, 8'd40, 8'd5}, '{8'd10, 8'd20, 8'd0}};

    ARESETn = 0; start = 0; stop = 0;
    min_angle = 0; max_angle = 0; step = 0; dwell_cycles = 0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1;
    @(negedge ACLK); #1;
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_awaddr", AWADDR, 0);
    chk("rst_wdata", WDATA, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_cur_angle", cur_angle, 0);
    chk("wstrb_const", WSTRB, 4'hF);
    chk("awprot_const", AWPROT, 0);

    // basic sweep, stop during a dwell
    test_id = 1; exp_int = 7; base = nb;
    push_wr(BASE + 32'd4, 32'h1111_1111);
    foreach (a_basic[i]) push_wr(BASE, a_basic[i]);
    push_wr(BASE + 32'd4, 32'h0);
    start_sweep(8'd10, 8'd30, 8'd10, 24'd4);
    @(negedge ACLK); #1;
    chk("busy_after_start", busy, 1);
    wait_nb(base + 7);
    pulse_stop;
    lat = 0;
    while (!AWVALID && lat < 10) begin
      @(negedge ACLK); #1;
      if (!AWVALID) lat++;
    end
    chk("stop_in_dwell_latency_le2", lat <= 2, 1);
    wait_idle;
    chk("basic_sb_empty", exp_q.size(), 0);
    chk("basic_cur_angle", cur_angle, 20);

    // clamp at max with overshoot, zero dwell treated as one cycle
    test_id = 2; exp_int = 4; base = nb;
    push_wr(BASE + 32'd4, 32'h1111_1111);
    foreach (a_clamp[i]) push_wr(BASE, a_clamp[i]);
    push_wr(BASE + 32'd4, 32'h0);
    start_sweep(8'd0, 8'd25, 8'd10, 24'd0);
    wait_nb(base + 9);
    pulse_stop;
    wait_idle;
    chk("clamp_sb_empty", exp_q.size(), 0);

    // stop while the angle write is stalled on AWREADY
    test_id = 3; exp_int = 0; aw_delay = 5; base = nb;
    push_wr(BASE + 32'd4, 32'h1111_1111);
    push_wr(BASE, 32'd40);
    push_wr(BASE + 32'd4, 32'h0);
    start_sweep(8'd40, 8'd60, 8'd20, 24'd2);
    t = 0;
    while (!(nb >= base + 1 && AWVALID) && t < 3000) begin @(negedge ACLK); #1; t++; end
    chk("stall_wait_timeout", t < 3000, 1);
    pulse_stop;
    wait_idle;
    chk("stall_sb_empty", exp_q.size(), 0);
    chk("stall_cur_angle", cur_angle, 40);

    // backpressure both orders; min==max==180 with a step that needs 9 bits
    for (int k = 0; k < 2; k++) begin
      test_id = 4 + k; aw_delay = bp_aw[k]; w_delay = bp_w[k]; base = nb;
      push_wr(BASE + 32'd4, 32'h1111_1111);
      repeat (3) push_wr(BASE, 32'd180);
      push_wr(BASE + 32'd4, 32'h0);
      start_sweep(8'd180, 8'd180, 8'd100, 24'd2);
      wait_nb(base + 4);
      pulse_stop;
      wait_idle;
      chk("bp_sb_empty", exp_q.size(), 0);
      chk("bp_cur_angle", cur_angle, 180);
    end
    aw_delay = 0; w_delay = 0;

    // invalid configurations
    test_id = 6;
    for (int k = 0; k < 3; k++) begin
      base = awv_cnt;
      start_sweep(inv[k][0], inv[k][1], inv[k][2], 24'd3);
      @(negedge ACLK); #1;
      chk("invalid_error", error, 1);
      chk("invalid_busy", busy, 0);
      repeat (3) @(negedge ACLK);
      #1;
      chk("invalid_no_awvalid", awv_cnt, base);
    end

    // SLVERR on the second angle write
    test_id = 7; err_idx = 2; base = nb;
    push_wr(BASE + 32'd4, 32'h1111_1111);
    push_wr(BASE, 32'd10);
    push_wr(BASE, 32'd20);
    push_wr(BASE + 32'd4, 32'h0);
    start_sweep(8'd10, 8'd30, 8'd10, 24'd3);
    @(negedge ACLK); #1;
    chk("error_cleared_by_start", error, 0);
    wait_idle;
    chk("bresp_error", error, 1);
    chk("bresp_cur_angle", cur_angle, 10);
    chk("bresp_sb_empty", exp_q.size(), 0);
    err_idx = -1;

    // asynchronous reset while W is waiting for WREADY
    test_id = 8; w_delay = 3;
    push_wr(BASE + 32'd4, 32'h1111_1111);
    start_sweep(8'd10, 8'd30, 8'd10, 24'd3);
    t = 0;
    while (!WVALID && t < 100) begin @(negedge ACLK); #1; t++; end
    chk("reset_wait_timeout", WVALID, 1);
    #1;
    ARESETn = 0;
    #1;
    chk("arst_awaddr", AWADDR, 0);
    chk("arst_wdata", WDATA, 0);
    chk("arst_wvalid", WVALID, 0);
    chk("arst_awvalid", AWVALID, 0);
    chk("arst_bready", BREADY, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cur_angle", cur_angle, 0);
    chk("arst_error", error, 0);
    exp_q.delete();
    repeat (2) @(negedge ACLK);
    ARESETn = 1;
    repeat (4) @(negedge ACLK);
    #1;
    chk("post_reset_idle", busy, 0);
    chk("post_reset_awvalid", AWVALID, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
